// File: rtl/chaos_decryption.sv
// Streaming inverse of the two-round permutation/substitution image cipher.
// One frame is loaded, unwound in place through two ping-pong buffers, then streamed out.
module chaos_decryption #(
  parameter int N_PIX = 256,
  parameter int AW    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] key_k,
  input  logic [7:0] key_f,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       busy
);
  typedef enum logic [2:0] {LOAD, SUB1, PERM1, SUB0, OUT} state_t;

  localparam logic [7:0]    RC1  = 8'h5C;
  localparam logic [AW-1:0] LAST = AW'(N_PIX - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] idx;
  logic [7:0]    k_q, f_q, lfsr;
  logic [7:0]    buf_a [N_PIX];
  logic [7:0]    buf_b [N_PIX];

  logic [7:0]    k1, f1, seed0, seed1, lfsr_nxt, chain, sub_val, ar, br;
  logic [AW+7:0] prod;
  logic [AW-1:0] perm_addr;
  logic          accept, fire, fire_last;

  assign k1        = k_q ^ RC1;
  assign f1        = f_q ^ RC1;
  assign seed0     = (k_q == 8'h00) ? 8'h01 : k_q;
  assign seed1     = (k1 == 8'h00) ? 8'h01 : k1;
  assign lfsr_nxt  = lfsr[0] ? ((lfsr >> 1) ^ 8'hB8) : (lfsr >> 1);

  // Inverse substitution: previous ciphertext pixel, or the round's chain seed at i==0
  assign chain     = (idx == '0) ? ((state == SUB1) ? f1 : f_q) : buf_a[idx - AW'(1)];
  assign sub_val   = buf_a[idx] ^ lfsr_nxt ^ chain;

  // PERM1 undoes round 1's affine shuffle, OUT undoes round 0's
  assign ar        = (state == OUT) ? {k_q[6:0], 1'b1} : {k1[6:0], 1'b1};
  assign br        = (state == OUT) ? f_q : f1;
  assign prod      = (AW+8)'(ar) * (AW+8)'(idx) + (AW+8)'(br);
  assign perm_addr = prod[AW-1:0];

  assign s_ready   = (state == LOAD);
  assign accept    = s_valid & s_ready;
  assign fire      = m_valid & m_ready;
  assign fire_last = fire & m_last;
  assign busy      = !((state == LOAD) && (idx == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (accept && idx == LAST) state_nxt = SUB1;
      SUB1:    if (idx == LAST)           state_nxt = PERM1;
      PERM1:   if (idx == LAST)           state_nxt = SUB0;
      SUB0:    if (idx == LAST)           state_nxt = OUT;
      OUT:     if (fire_last)             state_nxt = LOAD;
      default:                            state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      k_q     <= '0;
      f_q     <= '0;
      lfsr    <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else begin
      case (state)
        LOAD: if (accept) begin
          if (idx == '0) begin
            k_q <= key_k;
            f_q <= key_f;
          end
          if (idx == LAST) lfsr <= seed1;
          idx <= idx + AW'(1);
        end
        SUB1, SUB0: begin
          lfsr <= lfsr_nxt;
          idx  <= idx + AW'(1);
        end
        PERM1: begin
          if (idx == LAST) lfsr <= seed0;
          idx <= idx + AW'(1);
        end
        OUT: begin
          // Registered output stage: refill whenever empty or draining
          if (fire_last) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            idx     <= '0;
          end else if (!m_valid || m_ready) begin
            m_valid <= 1'b1;
            m_data  <= buf_b[perm_addr];
            m_last  <= (idx == LAST);
            idx     <= idx + AW'(1);
          end
        end
        default: idx <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      LOAD:       if (accept) buf_a[idx] <= s_data;
      SUB1, SUB0: buf_b[idx] <= sub_val;
      PERM1:      buf_a[idx] <= buf_b[perm_addr];
      default:    ;
    endcase
  end
endmodule

// File: tb/tb_chaos_decryption.sv
// Directed bench for chaos_decryption: frames are encrypted by a forward model here,
// decrypted by the DUT and compared against the original plaintext.
module tb_chaos_decryption;
  localparam int N = 256;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] key_k, key_f, s_data, m_data;
  logic       s_valid, s_ready, m_valid, m_ready, m_last, busy;

  chaos_decryption #(.N_PIX(N), .AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .key_k(key_k), .key_f(key_f),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] k;
    logic [7:0] f;
    int         pat;    // 0: i, 1: random, 2: 255-i
    int         stall;  // 1: m_ready high one cycle in three
    bit         hold;   // keep s_valid high after the frame is loaded
    bit         kchg;   // perturb keys after pixel 0
  } vec_t;

  int checks = 0, failures = 0;
  int acc_cnt = 0, acc0, lat, sr_bad, n_xfer, last_at, unstable, bad, first_bad;
  logic [7:0] plain [N];
  logic [7:0] cipher [N];

  always @(posedge clk) if (s_valid && s_ready) acc_cnt++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
  endfunction

  // Forward cipher: round 0 then round 1, permute then chained substitute
  function automatic void encrypt(input logic [7:0] k, input logic [7:0] f);
    logic [7:0] x [N];
    logic [7:0] y [N];
    logic [7:0] rc, kr, ar, s, prev;
    for (int i = 0; i < N; i++) x[i] = plain[i];
    for (int r = 0; r < 2; r++) begin
      rc = (r == 0) ? 8'h00 : 8'h5C;
      kr = k ^ rc;
      ar = {kr[6:0], 1'b1};
      for (int i = 0; i < N; i++) y[(int'(ar) * i + int'(f ^ rc)) % N] = x[i];
      s = (kr == 8'h00) ? 8'h01 : kr;
      prev = f ^ rc;
      for (int i = 0; i < N; i++) begin
        s = lfsr_step(s);
        x[i] = y[i] ^ s ^ prev;
        prev = x[i];
      end
    end
    for (int i = 0; i < N; i++) cipher[i] = x[i];
  endfunction

  task automatic drive_frame(input logic [7:0] k, input logic [7:0] f, input bit hold, input bit kchg);
    int i = 0, guard = 0;
    while (i < N && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (s_ready) begin
        s_valid = 1'b1;
        s_data  = cipher[i];
        key_k   = (kchg && i > 0) ? ~k : k;
        key_f   = (kchg && i > 0) ? (f ^ 8'h5A) : f;
        i++;
      end else s_valid = 1'b0;
    end
    chk("load_pixels_driven", i, N);
    @(negedge clk);
    s_valid = hold;
    s_data  = 8'hEE;
  endtask

  task automatic wait_out();
    lat = 0;
    sr_bad = 0;
    while (!m_valid && lat < 2000) begin
      if (s_ready) sr_bad++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic collect(input int stall);
    int cyc = 0;
    bit pv = 1'b0;
    logic [7:0] pdata = '0;
    logic plast = 1'b0;
    n_xfer = 0; last_at = -1; unstable = 0; bad = 0; first_bad = -1;
    while (last_at < 0 && n_xfer < N && cyc < 6000) begin
      if (pv && (!m_valid || m_data !== pdata || m_last !== plast)) unstable++;
      if (s_ready) sr_bad++;
      m_ready = (stall == 0) ? 1'b1 : (cyc % 3 == 0);
      if (m_valid && m_ready) begin
        if (m_data !== plain[n_xfer]) begin
          bad++;
          if (first_bad < 0) first_bad = n_xfer;
        end
        if (m_last) last_at = n_xfer;
        n_xfer++;
      end
      pv = m_valid && !m_ready;
      pdata = m_data;
      plast = m_last;
      cyc++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic make_plain(input int pat);
    for (int i = 0; i < N; i++)
      plain[i] = (pat == 0) ? 8'(i) : (pat == 2) ? 8'(255 - i) : 8'($urandom_range(0, 255));
  endtask

  task automatic run_vec(input vec_t v, input int id);
    make_plain(v.pat);
    encrypt(v.k, v.f);
    acc0 = acc_cnt;
    drive_frame(v.k, v.f, v.hold, v.kchg);
    wait_out();
    chk($sformatf("v%0d latency", id), lat, 3 * N + 1);
    collect(v.stall);
    chk($sformatf("v%0d s_ready_low_cycles_bad", id), sr_bad, 0);
    chk($sformatf("v%0d transfers", id), n_xfer, N);
    chk($sformatf("v%0d m_last_index", id), last_at, N - 1);
    chk($sformatf("v%0d stall_unstable", id), unstable, 0);
    chk($sformatf("v%0d data_mismatches(first=%0d)", id, first_bad), bad, 0);
    chk($sformatf("v%0d accepts", id), acc_cnt - acc0, N);
    chk($sformatf("v%0d idle_busy", id), int'(busy), 0);
    chk($sformatf("v%0d idle_s_ready", id), int'(s_ready), 1);
    chk($sformatf("v%0d idle_m_valid", id), int'(m_valid), 0);
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, " rst_s_ready"}, int'(s_ready), 1);
    chk({tag, " rst_m_valid"}, int'(m_valid), 0);
    chk({tag, " rst_busy"}, int'(busy), 0);
    chk({tag, " rst_m_data"}, int'(m_data), 0);
    chk({tag, " rst_m_last"}, int'(m_last), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t vecs [10];
    vec_t rv;
    vecs[0] = '{8'h00, 8'h00, 0, 0, 1'b0, 1'b0};
    vecs[1] = '{8'hA7, 8'h3C, 1, 0, 1'b0, 1'b0};
    vecs[2] = '{8'hA7, 8'h3C, 1, 0, 1'b0, 1'b0};
    vecs[3] = '{8'hA7, 8'h3C, 1, 0, 1'b0, 1'b0};
    vecs[4] = '{8'hA7, 8'h3C, 1, 0, 1'b0, 1'b0};
    vecs[5] = '{8'hA7, 8'h3C, 1, 1, 1'b0, 1'b0};
    vecs[6] = '{8'hA7, 8'h3C, 1, 0, 1'b1, 1'b0};
    vecs[7] = '{8'hA7, 8'h3C, 1, 0, 1'b0, 1'b1};
    vecs[8] = '{8'h5C, 8'h5C, 1, 1, 1'b0, 1'b0};
    vecs[9] = '{8'h00, 8'h81, 2, 0, 1'b1, 1'b0};

    rst_n = 1'b0; key_k = '0; key_f = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("por_s_ready", int'(s_ready), 1);
    chk("por_m_valid", int'(m_valid), 0);
    chk("por_busy", int'(busy), 0);
    chk("por_m_last", int'(m_last), 0);
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++) run_vec(vecs[v], v);

    // Reset while unwinding round 1
    make_plain(1);
    encrypt(8'hA7, 8'h3C);
    drive_frame(8'hA7, 8'h3C, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    chk("sub1 busy", int'(busy), 1);
    chk("sub1 s_ready", int'(s_ready), 0);
    reset_pulse("mid_sub1");
    rv = '{8'hA7, 8'h3C, 1, 0, 1'b0, 1'b0};
    run_vec(rv, 10);

    // Reset partway through the output stream
    make_plain(1);
    encrypt(8'h13, 8'hC4);
    drive_frame(8'h13, 8'hC4, 1'b0, 1'b0);
    wait_out();
    chk("mid_out latency", lat, 3 * N + 1);
    m_ready = 1'b1;
    repeat (40) @(negedge clk);
    chk("mid_out m_valid", int'(m_valid), 1);
    m_ready = 1'b0;
    reset_pulse("mid_out");
    rv = '{8'h13, 8'hC4, 1, 1, 1'b0, 1'b0};
    run_vec(rv, 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
